jstk_poller: RTL

Periodic transaction sequencer and data decoder that sits directly upstream and downstream of the PmodJSTK SPI wrapper. It issues a send/receive request at a fixed poll rate and drives the LED command byte. It waits for the wrapper's slave-select to complete a full low/high cycle, then captures and unpacks the 40-bit response into joystick position, buttons, button-press strobes and thresholded direction flags. It runs in the 100 MHz system clock domain.

---
 rtl/jstk_poller.sv | 131 +++++++++++++
 1 files changed

// File: rtl/jstk_poller.sv
// Poll sequencer and response decoder for the PmodJSTK SPI wrapper: requests a
// transfer every poll period, waits for a full SS low/high cycle, then unpacks the data.
module jstk_poller #(
  parameter int POLL_CYCLES    = 1_000_000,
  parameter int TIMEOUT_CYCLES = 200_000,
  parameter int DEADZONE       = 128
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        en,
  input  logic [1:0]  led,
  input  logic        SS,
  input  logic [39:0] DOUT,
  output logic        sndRec,
  output logic [7:0]  DIN,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic [2:0]  btn,
  output logic [2:0]  btn_press,
  output logic [3:0]  dir,
  output logic        valid,
  output logic        timeout
);

  localparam int PW = $clog2(POLL_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [10:0]   HI_LIM    = 11'(512 + DEADZONE);
  localparam logic [10:0]   LO_LIM    = 11'(512 - DEADZONE);

  typedef enum logic [1:0] {IDLE, REQ, BUSY, CAPTURE} state_t;

  state_t        state, next_state;
  logic          ss_meta, ss_s;
  logic [PW-1:0] poll_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          tick, tmo_hit;
  logic          start, capture, abort;
  logic [9:0]    new_x, new_y;
  logic [3:0]    new_dir;
  logic          unused_dout;

  // SS comes from another clock domain; only the synchronized copy is trusted
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ss_meta <= 1'b1;
      ss_s    <= 1'b1;
    end else begin
      ss_meta <= SS;
      ss_s    <= ss_meta;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)      poll_cnt <= '0;
    else if (tick) poll_cnt <= '0;
    else           poll_cnt <= poll_cnt + PW'(1);
  end

  assign tick    = (poll_cnt == POLL_LAST);
  assign tmo_hit = (tmo_cnt == TMO_LAST);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                                tmo_cnt <= '0;
    else if (start)                          tmo_cnt <= '0;
    else if (state == REQ || state == BUSY)  tmo_cnt <= tmo_cnt + TW'(1);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= next_state;
  end

  // Timeout wins over a simultaneous SS edge so an abort never races a capture
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (tick && en && ss_s) next_state = REQ;
      REQ:     if (tmo_hit) next_state = IDLE; else if (!ss_s) next_state = BUSY;
      BUSY:    if (tmo_hit) next_state = IDLE; else if (ss_s)  next_state = CAPTURE;
      CAPTURE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    sndRec  = 1'b0;
    start   = 1'b0;
    capture = 1'b0;
    abort   = 1'b0;
    case (state)
      IDLE:    start = (next_state == REQ);
      REQ:     begin sndRec = 1'b1; abort = tmo_hit; end
      BUSY:    abort = tmo_hit;
      CAPTURE: capture = 1'b1;
      default: ;
    endcase
  end

  assign new_x   = {DOUT[25:24], DOUT[39:32]};
  assign new_y   = {DOUT[9:8], DOUT[23:16]};
  assign new_dir = {({1'b0, new_y} > HI_LIM), ({1'b0, new_y} < LO_LIM),
                    ({1'b0, new_x} < LO_LIM), ({1'b0, new_x} > HI_LIM)};
  assign unused_dout = ^{DOUT[31:26], DOUT[15:10], DOUT[7:3]};

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      DIN       <= 8'h80;
      x         <= 10'd512;
      y         <= 10'd512;
      btn       <= 3'b000;
      btn_press <= 3'b000;
      dir       <= 4'b0000;
      valid     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      valid     <= capture;
      timeout   <= abort;
      btn_press <= capture ? (DOUT[2:0] & ~btn) : 3'b000;
      if (start) DIN <= {6'b100000, led};
      if (capture) begin
        x   <= new_x;
        y   <= new_y;
        btn <= DOUT[2:0];
        dir <= new_dir;
      end
    end
  end

endmodule
